serial_receiver: RTL and testbench
==================================

# serial_receiver

Asynchronous 8N1 serial receiver that turns the host link's RX line into byte strobes for the text-screen write collector. It oversamples the line 16× per bit, majority-votes each bit, validates start and stop bits, and presents each good byte on `received` with a `ready` pulse. The collector is edge-triggered on `ready`, so `received` is always stable before `ready` rises and stays stable while it is high.

## Interface
Parameters:
- `CLOCK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115200: line rate.
- `READY_CYCLES`, 2: width of the `ready` pulse in clocks (≥1).

Ports:
- `clock` in 1: system clock; the single clock domain.
- `reset_n` in 1: synchronous, active-low reset.
- `rx` in 1: raw serial line, asynchronous, idles high.
- `received` out 8: last good byte.
- `ready` out 1: byte-valid pulse.
- `framing_error` out 1: one-clock pulse when the stop bit samples low.

## Operation
- `rx` passes through a 2-flop synchronizer before any use.
- The tick generator divides `clock` by `DIV = round(CLOCK_HZ / (BAUD*16))`. It is free-running, restarts at 0 on entering START, and produces a one-clock `tick` every DIV clocks. DIV must be ≥2; an elaboration-time error fires otherwise.
- Sample index `s` counts 0..15 per bit on ticks. Bit value is the majority of the samples at s=7, 8, 9.
- FSM states:
  - ARM: after reset, wait until synced `rx` has been high for 16 consecutive ticks. This prevents locking onto a frame already in progress. Then go to IDLE.
  - IDLE: on a synced `rx` falling edge, go to START with `s`=0.
  - START: at s=15, if the voted bit is 1, treat it as a glitch and return to IDLE. Otherwise go to DATA with bit count 0.
  - DATA: at s=15, shift the voted bit into the shift register LSB-first. After bit 7, go to STOP.
  - STOP: the voted bit is evaluated at s=9, half a bit early, so back-to-back frames are not missed.
    - Bit = 1: load `received` from the shift register, then go to EMIT.
    - Bit = 0: pulse `framing_error`, leave `received` unchanged, and go to ARM.
  - EMIT: assert `ready` for READY_CYCLES clocks, then go to IDLE. A start edge arriving during EMIT is latched and processed once EMIT ends. Such an edge is at most READY_CYCLES clocks late, well under one tick.
- 0xFF bytes are passed unaltered; the collector uses them as resync markers.
- Reset values: `received` = 0x00, `ready` = 0, `framing_error` = 0, state = ARM, all counters = 0.
- Reset mid-frame discards the partial byte. No `ready` or `framing_error` is produced.

## Timing
- `received` updates on the clock edge in which STOP completes. `ready` rises on the next edge, so setup is one clock period.
- `ready` is high for exactly READY_CYCLES clocks. `received` holds until the next good frame, at least about 9.5 bit times later.
- Latency is about 9.6 bit times from the start-bit falling edge to `ready`, plus 3 clocks: 2 for the synchronizer and 1 for setup.
- Baud tolerance is ±3% cumulative mismatch, verified at ±2%.
- `framing_error` and `ready` are never high in the same cycle.

## Structure
- Package `serial_pkg` holds:
  - state enum: ARM, IDLE, START, DATA, STOP, EMIT;
  - constant `OVERSAMPLE` = 16;
  - function `baud_div(clock_hz, baud)`.
- Natural sub-module `baud_tick_gen`, covering the DIV counter, restart input and `tick` output. Everything else stays in `serial_receiver`.

## Test plan
- Reset release with `rx` high, then frame 0x41 at 115200 → after about 16 ticks in ARM, `received` = 0x41, `ready` high for 2 clocks, `received` stable one clock before `ready` rises.
- Frames 0xFF, 0x00, 0x55 back-to-back with no idle gap → three `ready` pulses with matching `received` values and no `framing_error`.
- Frame 0xA5 with stop bit held low → `framing_error` pulse, no `ready`, `received` keeps its prior value; the next valid 0x3C after `rx` idles 16 ticks is received.
- 3-tick low glitch on idle `rx` → START aborts, no outputs. A single-sample glitch inside a data bit of 0x81 → still 0x81.
- `reset_n` low during bit 4 of a frame, released while `rx` is low mid-frame → no output for that frame; the next full frame 0x7E is received correctly.
- Line clocked at BAUD+2% and BAUD−2% with 32 random bytes each → all bytes received correctly, zero framing errors.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the 8N1 serial receiver.
`timescale 1ns/1ps
package serial_pkg;

  // Samples taken per bit period.
  localparam int OVERSAMPLE = 16;

  // Receiver control states.
  typedef enum logic [2:0] {
    ARM,
    IDLE,
    START,
    DATA,
    STOP,
    EMIT
  } rx_state_e;

  // Clock divider for one oversample tick, rounded to nearest.
  function automatic int baud_div(input int clock_hz, input int baud);
    return (clock_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

  // Two-of-three vote used to reject single-sample noise.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick divider; restart realigns it to a start edge.
`timescale 1ns/1ps
module baud_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("baud_tick_gen: DIV must be at least 2");
    end
  endgenerate

  logic [CW-1:0] count;

  // Divider counter: wraps every DIV clocks, forced to zero on restart.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n || restart) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST) && !restart;

endmodule

// File: rtl/serial_receiver.sv
// 8N1 receiver: 16x oversampling, 3-sample majority vote, start/stop checks,
// byte strobe on ready with received held stable before and during the pulse.
`timescale 1ns/1ps
module serial_receiver import serial_pkg::*; #(
  parameter int CLOCK_HZ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int READY_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] received,
  output logic       ready,
  output logic       framing_error
);

  localparam int DIV = baud_div(CLOCK_HZ, BAUD);
  localparam int RCW = $clog2(READY_CYCLES + 1);

  generate
    if (READY_CYCLES < 1) begin : g_ready_check
      $error("serial_receiver: READY_CYCLES must be at least 1");
    end
  endgenerate

  logic           rx_meta, rx_sync, rx_prev;
  logic           fall_edge;
  logic           tick;
  logic           restart;
  logic           emit_done;
  logic           vote_now;

  rx_state_e      state;
  logic [3:0]     sample_idx;
  logic [2:0]     bit_cnt;
  logic [3:0]     arm_cnt;
  logic [7:0]     shift;
  logic [1:0]     mid_samples;
  logic           bit_vote;
  logic           start_pending;
  logic [RCW-1:0] emit_cnt;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (restart),
    .tick    (tick)
  );

  // Two-flop synchronizer on the raw line plus one stage for edge detection.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall_edge = rx_prev & ~rx_sync;

  // Vote over samples 7 and 8 (registered) and sample 9 (live line).
  assign vote_now = majority3(mid_samples[1], mid_samples[0], rx_sync);

  // Decide when a new frame begins, which also realigns the tick divider.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    emit_done = (emit_cnt == RCW'(READY_CYCLES));
    restart   = 1'b0;
    case (state)
      IDLE:    restart = fall_edge;
      EMIT:    restart = emit_done && (start_pending || fall_edge);
      default: restart = 1'b0;
    endcase
  end

  // Receiver FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ARM;
      sample_idx    <= '0;
      bit_cnt       <= '0;
      arm_cnt       <= '0;
      shift         <= '0;
      mid_samples   <= '0;
      bit_vote      <= 1'b0;
      start_pending <= 1'b0;
      emit_cnt      <= '0;
      received      <= '0;
      ready         <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      ready         <= 1'b0;
      framing_error <= 1'b0;

      // Oversample bookkeeping shared by every in-frame state; wraps 15 -> 0.
      if (tick && (state inside {START, DATA, STOP})) begin
        sample_idx <= sample_idx + 4'd1;
        if (sample_idx == 4'd7) mid_samples[0] <= rx_sync;
        if (sample_idx == 4'd8) mid_samples[1] <= rx_sync;
        if (sample_idx == 4'd9) bit_vote       <= vote_now;
      end

      case (state)
        ARM: begin
          // Require a full bit time of idle line before listening.
          if (!rx_sync) begin
            arm_cnt <= '0;
          end else if (tick) begin
            if (arm_cnt == 4'd15) begin
              arm_cnt <= '0;
              state   <= IDLE;
            end else begin
              arm_cnt <= arm_cnt + 4'd1;
            end
          end
        end

        IDLE: begin
          if (restart) begin
            sample_idx <= '0;
            state      <= START;
          end
        end

        START: begin
          if (tick && sample_idx == 4'd15) begin
            if (bit_vote) begin
              state <= IDLE;
            end else begin
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
        end

        DATA: begin
          if (tick && sample_idx == 4'd15) begin
            shift   <= {bit_vote, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end

        STOP: begin
          // Decided half a bit early so a back-to-back start edge is not missed.
          if (tick && sample_idx == 4'd9) begin
            if (vote_now) begin
              received      <= shift;
              emit_cnt      <= '0;
              start_pending <= 1'b0;
              state         <= EMIT;
            end else begin
              framing_error <= 1'b1;
              arm_cnt       <= '0;
              state         <= ARM;
            end
          end
        end

        EMIT: begin
          if (emit_done) begin
            sample_idx    <= '0;
            start_pending <= 1'b0;
            state         <= restart ? START : IDLE;
          end else begin
            ready    <= 1'b1;
            emit_cnt <= emit_cnt + RCW'(1);
            if (fall_edge) start_pending <= 1'b1;
          end
        end

        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: table-driven frames, hand-written
// corner sequences and randomized bytes at +/-2% baud against a queue model.
// Baud is scaled down (DIV = 4) to keep run length modest.
`timescale 1ns/1ps
module tb_serial_receiver;

  localparam int  CLOCK_HZ     = 640_000;
  localparam int  BAUD         = 10_000;
  localparam int  READY_CYCLES = 2;
  localparam real CLK_NS       = 10.0;
  localparam real BIT_NS       = CLK_NS * CLOCK_HZ / BAUD;
  localparam real TICK_NS      = BIT_NS / 16.0;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [7:0] received;
  logic       ready;
  logic       framing_error;

  int errors = 0;
  int checks = 0;

  // Model state: bytes still owed by the DUT, plus observed event counts.
  logic [7:0] exp_q[$];
  int         ready_count = 0;
  int         ferr_count  = 0;
  int         ready_width = 0;
  logic       ready_q     = 1'b0;
  logic [7:0] received_q  = 8'h00;
  int         r0, f0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap_bits;
    int         exp_ready;
    int         exp_ferr;
    logic [7:0] exp_rx;
  } vec_t;

  always #(CLK_NS / 2.0) clock = ~clock;

  serial_receiver #(
    .CLOCK_HZ     (CLOCK_HZ),
    .BAUD         (BAUD),
    .READY_CYCLES (READY_CYCLES)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx            (rx),
    .received      (received),
    .ready         (ready),
    .framing_error (framing_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame; optionally flip the line for one tick mid data bit.
  task automatic send_frame(input logic [7:0] data, input logic stop, input real bit_ns,
                            input int glitch_bit, input bit expect_ok);
    if (expect_ok) exp_q.push_back(data);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == glitch_bit) begin
        #(bit_ns * 0.5);
        rx = ~data[i];
        #(bit_ns / 16.0);
        rx = data[i];
        #(bit_ns * 0.5 - bit_ns / 16.0);
      end else begin
        #(bit_ns);
      end
    end
    rx = stop;
    #(bit_ns);
    rx = 1'b1;
  endtask

  // Output monitor: byte order/value, setup and hold of received, pulse width,
  // mutual exclusion of ready and framing_error.
  always @(negedge clock) begin
    if (reset_n) begin
      if (ready && !ready_q) begin
        check("received_setup", 32'(received), 32'(received_q));
        check("ready_has_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("received_value", 32'(received), 32'(exp_q.pop_front()));
        ready_count <= ready_count + 1;
      end
      if (ready && ready_q) check("received_hold", 32'(received), 32'(received_q));
      if (!ready && ready_q) begin
        check("ready_width", 32'(ready_width), 32'(READY_CYCLES));
        ready_width <= 0;
      end else if (ready) begin
        ready_width <= ready_width + 1;
      end
      if (ready || framing_error) check("ready_ferr_exclusive", 32'(ready & framing_error), 32'd0);
      if (framing_error) ferr_count <= ferr_count + 1;
    end else begin
      ready_width <= 0;
    end
    ready_q    <= ready;
    received_q <= received;
  end

  initial begin
    vec_t       vecs[6];
    real        bn;
    logic [7:0] b;

    vecs[0] = '{8'h41, 1'b1, 2, 1, 0, 8'h41};
    vecs[1] = '{8'hA5, 1'b0, 2, 0, 1, 8'h41};
    vecs[2] = '{8'h3C, 1'b1, 2, 1, 0, 8'h3C};
    vecs[3] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
    vecs[4] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    vecs[5] = '{8'h55, 1'b1, 2, 1, 0, 8'h55};

    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (4) @(negedge clock);
    check("reset_received", 32'(received), 32'h00);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_ferr", 32'(framing_error), 32'd0);

    // A frame starting right at reset release is ignored while arming.
    #2;
    reset_n = 1'b1;
    r0 = ready_count;
    f0 = ferr_count;
    send_frame(8'h00, 1'b1, BIT_NS, -1, 1'b0);
    #(2 * BIT_NS);
    check("arm_ignore_ready", 32'(ready_count - r0), 32'd0);
    check("arm_ignore_ferr", 32'(ferr_count - f0), 32'd0);

    // Table: good frames, framing error, back-to-back frames without gaps.
    for (int i = 0; i < 6; i++) begin
      r0 = ready_count;
      f0 = ferr_count;
      send_frame(vecs[i].data, vecs[i].stop, BIT_NS, -1, vecs[i].stop);
      check($sformatf("vec%0d_ready", i), 32'(ready_count - r0), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_count - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_received", i), 32'(received), 32'(vecs[i].exp_rx));
      #(vecs[i].gap_bits * BIT_NS);
    end

    // Short low glitch on an idle line aborts in START.
    r0 = ready_count;
    f0 = ferr_count;
    rx = 1'b0;
    #(3 * TICK_NS);
    rx = 1'b1;
    #(2 * BIT_NS);
    check("glitch_ready", 32'(ready_count - r0), 32'd0);
    check("glitch_ferr", 32'(ferr_count - f0), 32'd0);
    check("glitch_received", 32'(received), 32'h55);

    // One-sample glitch inside data bit 3 is voted away.
    r0 = ready_count;
    send_frame(8'h81, 1'b1, BIT_NS, 3, 1'b1);
    check("vote_ready", 32'(ready_count - r0), 32'd1);
    check("vote_received", 32'(received), 32'h81);
    #(2 * BIT_NS);

    // Reset asserted in bit 4, released while the line is low in bit 5.
    r0 = ready_count;
    f0 = ferr_count;
    fork
      send_frame(8'h0F, 1'b1, BIT_NS, -1, 1'b0);
      begin
        #(5.5 * BIT_NS);
        reset_n = 1'b0;
        #(0.8 * BIT_NS);
        reset_n = 1'b1;
      end
    join
    check("midreset_ready", 32'(ready_count - r0), 32'd0);
    check("midreset_ferr", 32'(ferr_count - f0), 32'd0);
    check("midreset_received", 32'(received), 32'h00);
    #(2 * BIT_NS);
    r0 = ready_count;
    send_frame(8'h7E, 1'b1, BIT_NS, -1, 1'b1);
    check("after_reset_ready", 32'(ready_count - r0), 32'd1);
    check("after_reset_received", 32'(received), 32'h7E);
    #(2 * BIT_NS);

    // Random bytes with the line 2% fast, then 2% slow.
    for (int k = 0; k < 2; k++) begin
      bn = (k == 0) ? BIT_NS / 1.02 : BIT_NS / 0.98;
      r0 = ready_count;
      f0 = ferr_count;
      for (int i = 0; i < 32; i++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1, bn, -1, 1'b1);
        if ($urandom_range(0, 1) == 1) #(bn);
      end
      #(2 * BIT_NS);
      check($sformatf("drift%0d_ready", k), 32'(ready_count - r0), 32'd32);
      check($sformatf("drift%0d_ferr", k), 32'(ferr_count - f0), 32'd0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
